// File: rtl/npu_pkg.sv
// Shared NPU definitions: band loader state encoding, lane count and the
// stride normalisation used when a map is started.
package npu_pkg;

  localparam int LANES = 3;

  typedef enum logic [2:0] {
    BL_IDLE,
    BL_FETCH,
    BL_DRAIN,
    BL_READY,
    BL_DONE
  } bl_state_t;

  // A zero stride would never advance the band, so it is promoted to one.
  function automatic logic [1:0] norm_stride(input logic [1:0] s);
    return (s == 2'd0) ? 2'd1 : s;
  endfunction

endpackage

// File: rtl/band_addr_gen.sv
// Band/column/lane counters for the band loader and the registered pixel
// memory address (b + lane) * COLS + c that goes with them.
module band_addr_gen
  import npu_pkg::*;
#(
  parameter int COLS   = 28,
  parameter int ROWS   = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              advance,
  input  logic [1:0]        stride,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        lane,
  output logic              last_issue,
  output logic              band_fits
);

  localparam int B_W = $clog2(ROWS);
  localparam int C_W = $clog2(COLS);
  localparam logic [1:0]     LAST_LANE = 2'(LANES - 1);
  localparam logic [C_W-1:0] C_LAST    = C_W'(COLS - 1);
  localparam logic [B_W:0]   B_MAX     = (B_W+1)'(ROWS - 3);

  logic [B_W-1:0]    b_reg, b_next;
  logic [C_W-1:0]    c_reg, c_next;
  logic [1:0]        lane_reg, lane_next;
  logic [1:0]        stride_reg, stride_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] row_next;
  logic [B_W:0]      b_sum;

  // One bit wider than b so the last-band test cannot wrap.
  assign b_sum     = {1'b0, b_reg} + (B_W+1)'(stride_reg);
  assign band_fits = (b_sum <= B_MAX);

  always_comb begin
    b_next      = b_reg;
    c_next      = c_reg;
    lane_next   = lane_reg;
    stride_next = stride_reg;
    if (load) begin
      stride_next = norm_stride(stride);
      b_next      = '0;
      c_next      = '0;
      lane_next   = '0;
    end else if (advance) begin
      b_next    = b_sum[B_W-1:0];
      c_next    = '0;
      lane_next = '0;
    end else if (step) begin
      if (lane_reg == LAST_LANE) begin
        lane_next = '0;
        c_next    = (c_reg == C_LAST) ? '0 : c_reg + 1'b1;
      end else begin
        lane_next = lane_reg + 2'd1;
      end
    end
    row_next  = ADDR_W'(b_next) + ADDR_W'(lane_next);
    addr_next = row_next * ADDR_W'(COLS) + ADDR_W'(c_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_reg      <= '0;
      c_reg      <= '0;
      lane_reg   <= '0;
      stride_reg <= 2'd1;
      addr_reg   <= '0;
    end else begin
      b_reg      <= b_next;
      c_reg      <= c_next;
      lane_reg   <= lane_next;
      stride_reg <= stride_next;
      addr_reg   <= addr_next;
    end
  end

  assign mem_addr   = addr_reg;
  assign lane       = lane_reg;
  assign last_issue = (lane_reg == LAST_LANE) && (c_reg == C_LAST);

endmodule

// File: rtl/band_loader.sv
// Streams 3-row bands of a row-major feature map out of pixel memory, one
// column per wr_en, and waits for the consumer between bands.
module band_loader
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic                 band_next,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [BIT_DEPTH-1:0] mem_rd_data,
  output logic                 wr_en,
  output logic [BIT_DEPTH-1:0] data_out_r1,
  output logic [BIT_DEPTH-1:0] data_out_r2,
  output logic [BIT_DEPTH-1:0] data_out_r3,
  output logic                 band_ready,
  output logic                 busy,
  output logic                 done
);

  bl_state_t state;
  logic mem_rd_en_reg, band_ready_reg, busy_reg, done_reg;
  logic rd_valid_reg, wr_en_reg;
  logic [1:0] rd_lane_reg, lane;
  logic [BIT_DEPTH-1:0] hold0_reg, hold1_reg, r1_reg, r2_reg, r3_reg;
  logic last_issue, band_fits, load, step, advance;

  assign load    = (state == BL_IDLE) && start;
  assign step    = (state == BL_FETCH);
  assign advance = (state == BL_READY) && band_next && band_fits;

  band_addr_gen #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .advance    (advance),
    .stride     (stride),
    .mem_addr   (mem_addr),
    .lane       (lane),
    .last_issue (last_issue),
    .band_fits  (band_fits)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BL_IDLE;
      mem_rd_en_reg  <= 1'b0;
      band_ready_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        BL_IDLE: begin
          if (start) begin
            state         <= BL_FETCH;
            mem_rd_en_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        BL_FETCH: begin
          if (last_issue) begin
            state         <= BL_DRAIN;
            mem_rd_en_reg <= 1'b0;
          end
        end
        // The last column's strobe marks the band as fully written.
        BL_DRAIN: begin
          if (wr_en_reg) begin
            state          <= BL_READY;
            band_ready_reg <= 1'b1;
          end
        end
        BL_READY: begin
          if (band_next) begin
            band_ready_reg <= 1'b0;
            if (band_fits) begin
              state         <= BL_FETCH;
              mem_rd_en_reg <= 1'b1;
            end else begin
              state    <= BL_DONE;
              done_reg <= 1'b1;
            end
          end
        end
        BL_DONE: begin
          state    <= BL_IDLE;
          busy_reg <= 1'b0;
        end
        default: state <= BL_IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its strobe; track which lane it is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_lane_reg  <= '0;
      hold0_reg    <= '0;
      hold1_reg    <= '0;
      r1_reg       <= '0;
      r2_reg       <= '0;
      r3_reg       <= '0;
      wr_en_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= mem_rd_en_reg;
      rd_lane_reg  <= lane;
      wr_en_reg    <= 1'b0;
      if (rd_valid_reg) begin
        case (rd_lane_reg)
          2'd0: hold0_reg <= mem_rd_data;
          2'd1: hold1_reg <= mem_rd_data;
          default: begin
            r1_reg    <= hold0_reg;
            r2_reg    <= hold1_reg;
            r3_reg    <= mem_rd_data;
            wr_en_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mem_rd_en   = mem_rd_en_reg;
  assign wr_en       = wr_en_reg;
  assign data_out_r1 = r1_reg;
  assign data_out_r2 = r2_reg;
  assign data_out_r3 = r3_reg;
  assign band_ready  = band_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_band_loader.sv
// Scoreboard bench for band_loader: a 28x28 instance over a ramp map and a
// minimal 3x4 instance; expected columns are queued, monitors pop on wr_en.
module tb_band_loader;

  localparam int R0 = 28, C0 = 28, A0 = 10;
  localparam int R1 = 3,  C1 = 4,  A1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start0, band_next0, mem_rd_en0, wr_en0, band_ready0, busy0, done0;
  logic [1:0]    stride0;
  logic [A0-1:0] mem_addr0;
  logic [7:0]    mem_rd_data0, d0_r1, d0_r2, d0_r3;
  logic          start1, band_next1, mem_rd_en1, wr_en1, band_ready1, busy1, done1;
  logic [1:0]    stride1;
  logic [A1-1:0] mem_addr1;
  logic [7:0]    mem_rd_data1, d1_r1, d1_r2, d1_r3;

  band_loader #(.BIT_DEPTH(8), .COLS(C0), .ROWS(R0), .ADDR_W(A0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stride(stride0), .band_next(band_next0),
    .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0), .mem_rd_data(mem_rd_data0),
    .wr_en(wr_en0), .data_out_r1(d0_r1), .data_out_r2(d0_r2), .data_out_r3(d0_r3),
    .band_ready(band_ready0), .busy(busy0), .done(done0));

  band_loader #(.BIT_DEPTH(8), .COLS(C1), .ROWS(R1), .ADDR_W(A1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stride(stride1), .band_next(band_next1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
    .wr_en(wr_en1), .data_out_r1(d1_r1), .data_out_r2(d1_r2), .data_out_r3(d1_r3),
    .band_ready(band_ready1), .busy(busy1), .done(done1));

  // Ramp pixel memories: value = address mod 256.
  logic [7:0] ram0 [0:1023];
  logic [7:0] ram1 [0:15];
  always @(posedge clk) if (mem_rd_en0) mem_rd_data0 <= ram0[mem_addr0];
  always @(posedge clk) if (mem_rd_en1) mem_rd_data1 <= ram1[mem_addr1];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int r1;
    int r2;
    int r3;
    int cyc;
  } col_t;

  col_t q0[$], q1[$];
  col_t e0, e1;
  int done_cnt0 = 0, br_cnt0 = 0, done_cnt1 = 0;
  logic br_prev0 = 1'b0;

  always @(negedge clk) begin
    if (wr_en0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0_wr_en: strobe at cycle %0d, expected none", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("u0_r1", int'(d0_r1), e0.r1);
        chk("u0_r2", int'(d0_r2), e0.r2);
        chk("u0_r3", int'(d0_r3), e0.r3);
        chk("u0_wr_cycle", cyc, e0.cyc);
      end
    end
    if (done0) done_cnt0++;
    if (band_ready0 && !br_prev0) br_cnt0++;
    br_prev0 = band_ready0;
  end

  always @(negedge clk) begin
    if (wr_en1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u1_wr_en: strobe at cycle %0d, expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("u1_r1", int'(d1_r1), e1.r1);
        chk("u1_r2", int'(d1_r2), e1.r2);
        chk("u1_r3", int'(d1_r3), e1.r3);
        chk("u1_wr_cycle", cyc, e1.cyc);
      end
    end
    if (done1) done_cnt1++;
  end

  task automatic push_band0(input int b, input int base, input int ncols);
    col_t e;
    for (int c = 0; c < ncols; c++) begin
      e.r1  = (b * C0 + c) % 256;
      e.r2  = ((b + 1) * C0 + c) % 256;
      e.r3  = ((b + 2) * C0 + c) % 256;
      e.cyc = base + 3 * c + 4;
      q0.push_back(e);
    end
  endtask

  task automatic reset_mid_fetch();
    int base;
    @(negedge clk); start0 = 1'b1; stride0 = 2'd1;
    @(posedge clk); #1; start0 = 1'b0; base = cyc;
    push_band0(0, base, 2);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_wr_en", int'(wr_en0), 0);
    chk("rst_mid_rd_en", int'(mem_rd_en0), 0);
    chk("rst_mid_addr", int'(mem_addr0), 0);
    chk("rst_mid_r1", int'(d0_r1), 0);
    chk("rst_mid_r2", int'(d0_r2), 0);
    chk("rst_mid_r3", int'(d0_r3), 0);
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_ready", int'(band_ready0), 0);
    chk("rst_mid_done", int'(done0), 0);
    chk("rst_mid_cols_left", q0.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_after_busy", int'(busy0), 0);
    chk("rst_after_rd_en", int'(mem_rd_en0), 0);
  endtask

  task automatic run_map0(input logic [1:0] s_in, input int exp_bands, input bit ign);
    int s, b, base, n;
    s = (s_in == 2'd0) ? 1 : int'(s_in);
    b = 0;
    done_cnt0 = 0;
    br_cnt0 = 0;
    @(negedge clk); start0 = 1'b1; stride0 = s_in;
    @(posedge clk); #1; start0 = 1'b0; stride0 = s_in + 2'd1;
    base = cyc;
    chk("u0_first_rd_en", int'(mem_rd_en0), 1);
    chk("u0_first_addr", int'(mem_addr0), 0);
    while (1) begin
      push_band0(b, base, C0);
      if (ign && b == 0) begin
        @(negedge clk); band_next0 = 1'b1;
        repeat (20) @(negedge clk);
        start0 = 1'b1; stride0 = 2'd3;
        @(negedge clk); start0 = 1'b0;
        repeat (40) @(negedge clk);
        band_next0 = 1'b0;
        chk("u0_busy_ignore", int'(busy0), 1);
      end
      n = 0;
      @(negedge clk);
      while (!band_ready0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!band_ready0) begin
        tests++;
        fails++;
        $display("FAIL u0_band_ready_wait: band_ready still 0 after 400 cycles, expected 1");
        return;
      end
      chk("u0_ready_cycle", cyc, base + 3 * C0 + 2);
      chk("u0_cols_left", q0.size(), 0);
      if (ign && b == 0) begin
        repeat (5) @(negedge clk);
        chk("u0_ready_hold", int'(band_ready0), 1);
      end
      band_next0 = 1'b1;
      @(posedge clk); #1; band_next0 = 1'b0;
      chk("u0_ready_drop", int'(band_ready0), 0);
      if (b + s + 2 <= R0 - 1) begin
        b = b + s;
        base = cyc;
        chk("u0_next_rd_en", int'(mem_rd_en0), 1);
        chk("u0_next_addr", int'(mem_addr0), b * C0);
      end else begin
        chk("u0_done_pulse", int'(done0), 1);
        chk("u0_busy_at_done", int'(busy0), 1);
        @(posedge clk); #1;
        chk("u0_done_clear", int'(done0), 0);
        chk("u0_busy_clear", int'(busy0), 0);
        break;
      end
    end
    repeat (10) @(negedge clk);
    chk("u0_done_count", done_cnt0, 1);
    chk("u0_band_count", br_cnt0, exp_bands);
    chk("u0_idle_busy", int'(busy0), 0);
  endtask

  task automatic run_small();
    int base, n;
    col_t e;
    done_cnt1 = 0;
    @(negedge clk); start1 = 1'b1; stride1 = 2'd1;
    @(posedge clk); #1; start1 = 1'b0; base = cyc;
    for (int c = 0; c < C1; c++) begin
      e.r1 = c; e.r2 = C1 + c; e.r3 = 2 * C1 + c; e.cyc = base + 3 * c + 4;
      q1.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!band_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("u1_ready_cycle", cyc, base + 3 * C1 + 2);
    chk("u1_cols_left", q1.size(), 0);
    band_next1 = 1'b1;
    @(posedge clk); #1; band_next1 = 1'b0;
    chk("u1_done_pulse", int'(done1), 1);
    chk("u1_ready_drop", int'(band_ready1), 0);
    chk("u1_no_fetch", int'(mem_rd_en1), 0);
    @(posedge clk); #1;
    chk("u1_done_clear", int'(done1), 0);
    chk("u1_busy_clear", int'(busy1), 0);
    repeat (10) @(negedge clk);
    chk("u1_done_count", done_cnt1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench still running at 1 ms, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram0[i] = 8'(i % 256);
    for (int i = 0; i < 16; i++) ram1[i] = 8'(i);
    rst = 1'b0;
    start0 = 1'b0; stride0 = 2'd0; band_next0 = 1'b0;
    start1 = 1'b0; stride1 = 2'd0; band_next1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ready", int'(band_ready0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_rd_en", int'(mem_rd_en0), 0);
    chk("rst_u1_busy", int'(busy1), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    reset_mid_fetch();
    run_map0(2'd1, 26, 1'b1);
    run_map0(2'd2, 13, 1'b0);
    run_map0(2'd0, 26, 1'b0);
    run_map0(2'd3, 9, 1'b0);
    run_small();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
